// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART receive path
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_t;

    // Clocks per bit, rounded to nearest so the mid-bit sample drifts least.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with occupancy-based full/empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero while empty so the output is defined out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 serial receiver feeding a FWFT byte FIFO with sticky error flags
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               i_clk_50mhz,
    input  logic                               i_reset,
    input  logic                               i_rx,
    output logic [UART_DATA_W-1:0]             o_data,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_level,
    output logic                               o_frame_err,
    output logic                               o_overrun,
    input  logic                               i_clr_err
);

    localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    uart_rx_state_t         state;
    uart_rx_state_t         state_next;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic                   tick;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shift;
    logic                   load_half;
    logic                   load_full;
    logic                   shift_en;
    logic                   push_req;
    logic                   frame_set;
    logic                   overrun_set;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign tick        = (cnt == '0);
    assign o_valid     = !fifo_empty;
    // A byte is lost only if the FIFO is full and nothing leaves this cycle.
    assign overrun_set = push_req && fifo_full && !(o_valid && i_ready);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge i_clk_50mhz) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk_50mhz) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    // FSM next-state decode; every sample happens on the cycle the counter hits zero.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (!rx_s) state_next = ST_START;
            ST_START:     if (tick) state_next = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (tick && bit_idx == 3'd7) state_next = ST_STOP;
            ST_STOP:      if (tick) state_next = rx_s ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (rx_s) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: counter reloads, shift strobe, FIFO push and framing error.
    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state)
            ST_IDLE:  load_half = !rx_s;
            ST_START: load_full = tick && !rx_s;
            ST_DATA: begin
                load_full = tick;
                shift_en  = tick;
            end
            ST_STOP: begin
                push_req  = tick && rx_s;
                frame_set = tick && !rx_s;
            end
            default: ;
        endcase
    end

    // Down-counter: half a bit to the start-bit centre, then whole bits.
    always_ff @(posedge i_clk_50mhz) begin
        if (i_reset)        cnt <= '0;
        else if (load_half) cnt <= CW'(HALF - 1);
        else if (load_full) cnt <= CW'(CPB - 1);
        else if (!tick)     cnt <= cnt - CW'(1);
    end

    // LSB-first shifter and bit index, restarted on every start bit.
    always_ff @(posedge i_clk_50mhz) begin
        if (i_reset) begin
            shift   <= '0;
            bit_idx <= '0;
        end else if (state == ST_START) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            shift   <= {rx_s, shift[UART_DATA_W-1:1]};
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Sticky error flags; a same-cycle set wins over the clear pulse.
    always_ff @(posedge i_clk_50mhz) begin
        if (i_reset) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (frame_set)      o_frame_err <= 1'b1;
            else if (i_clr_err) o_frame_err <= 1'b0;
            if (overrun_set)    o_overrun   <= 1'b1;
            else if (i_clr_err) o_overrun   <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk_50mhz),
        .reset (i_reset),
        .push  (push_req),
        .pop   (i_ready),
        .din   (shift),
        .dout  (o_data),
        .level (o_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

    // 50 MHz / 3 Mbaud: (50e6 + 1.5e6) / 3e6 = 17 clocks per bit, half = 8.
    localparam int CPB  = 17;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [3:0] level;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .CLK_HZ     (50_000_000),
        .BAUD       (3_000_000),
        .FIFO_DEPTH (8)
    ) dut (
        .i_clk_50mhz (clk),
        .i_reset     (reset),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_level     (level),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .i_clr_err   (clr_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data", data);
            end else begin
                check("pop_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Called just after a rising edge; drives start, 8 data bits LSB first, stop.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int low_tail);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        if (low_tail > 0) begin
            rx = 1'b0;
            repeat (low_tail) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 40 && valid; i++) begin
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
        check("drain_empty_valid", {31'd0, valid}, 32'd0);
        check("drain_empty_level", {28'd0, level}, 32'd0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pb;
        reset   = 1'b1;
        rx      = 1'b1;
        ready   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Two bytes held, then one pop; also pins down push latency.
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1, 0);
            begin
                repeat (2 + HALF + 9 * CPB) @(posedge clk);
                #1;
                check("valid_before_push", {31'd0, valid}, 32'd0);
                @(posedge clk);
                #1;
                check("valid_after_push", {31'd0, valid}, 32'd1);
            end
        join
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1;
        check("two_level", {28'd0, level}, 32'd2);
        check("two_head", {24'd0, data}, 32'h55);
        check("two_frame_err", {31'd0, frame_err}, 32'd0);
        check("two_overrun", {31'd0, overrun}, 32'd0);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check("one_level", {28'd0, level}, 32'd1);
        check("one_head", {24'd0, data}, 32'hA3);
        drain();

        // Short low glitch is rejected at the start-bit sample.
        rx = 1'b0;
        repeat (HALF - 1) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("glitch_level", {28'd0, level}, 32'd0);
        check("glitch_valid", {31'd0, valid}, 32'd0);
        check("glitch_frame_err", {31'd0, frame_err}, 32'd0);

        // Bad stop bit followed by a held-low break: one error, no byte.
        fork
            send_frame(8'h3C, 1'b0, 3 * CPB);
            begin
                for (int i = 0; i < 400 && !frame_err; i++) begin
                    @(posedge clk);
                    #1;
                end
                check("ferr_set", {31'd0, frame_err}, 32'd1);
                check("ferr_level", {28'd0, level}, 32'd0);
                pulse_clr();
                check("ferr_cleared", {31'd0, frame_err}, 32'd0);
            end
        join
        repeat (10 * CPB) @(posedge clk);
        #1;
        check("ferr_once", {31'd0, frame_err}, 32'd0);
        check("ferr_no_byte", {28'd0, level}, 32'd0);

        // Nine bytes into eight slots: the ninth is dropped.
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("ovr_level", {28'd0, level}, 32'd8);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_frame_err", {31'd0, frame_err}, 32'd0);
        pulse_clr();
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        drain();

        // Full FIFO with a pop exactly at the stop sample takes the new byte.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h11 + 8'(i));
            send_frame(8'h11 + 8'(i), 1'b1, 0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("full_level", {28'd0, level}, 32'd8);
        exp_q.push_back(8'h19);
        fork
            send_frame(8'h19, 1'b1, 0);
            begin
                repeat (2 + HALF + 9 * CPB) @(posedge clk);
                #1;
                ready = 1'b1;
                @(posedge clk);
                #1;
                ready = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check("fullpop_level", {28'd0, level}, 32'd8);
        check("fullpop_overrun", {31'd0, overrun}, 32'd0);
        drain();

        // Reset in the middle of data bit 4 with two bytes buffered.
        exp_q.push_back(8'h61);
        send_frame(8'h61, 1'b1, 0);
        exp_q.push_back(8'h62);
        send_frame(8'h62, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1;
        check("prerst_level", {28'd0, level}, 32'd2);
        pb = 8'h77;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            rx = pb[k];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = pb[4];
        repeat (HALF) @(posedge clk);
        #1;
        reset = 1'b1;
        rx    = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_level", {28'd0, level}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_data", {24'd0, data}, 32'd0);
        repeat (10 * CPB) @(posedge clk);
        #1;
        check("midrst_no_stale", {28'd0, level}, 32'd0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1;
        check("after_rst_level", {28'd0, level}, 32'd1);
        check("after_rst_head", {24'd0, data}, 32'h7E);
        drain();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
